tone_sequencer: RTL

- Multi-channel music sequencer; successor to the single-voice SRAM note player.
- Fetches 16-bit instruction words from external SRAM and decodes note and setting words.
- Runs up to CHANNELS independent square-wave voices, mixed onto SPEAKER.
- Tempo is runtime-programmable: a sequential divider recomputes the tick period on every BPM change.

---
 rtl/tone_pkg.sv | 70 +++++++
 rtl/tone_voice.sv | 49 ++++
 rtl/tone_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: instruction fields,
// opcodes, FSM states and the semitone half-period table.
package tone_pkg;

  localparam logic [2:0] OP_SET_BPM = 3'd0;
  localparam logic [2:0] OP_END     = 3'd1;
  localparam logic [2:0] OP_JUMP    = 3'd2;

  localparam int F_SET      = 15;
  localparam int F_SEL_LSB  = 12;
  localparam int F_HOLD     = 11;
  localparam int F_DUR_LSB  = 8;
  localparam int F_OCT_LSB  = 4;
  localparam int F_SEMI_LSB = 0;

  // C0 at 50 MHz needs 21 bits before any octave shift.
  localparam int HALF_W = 21;

  localparam logic [HALF_W-1:0] HALF_C0  = 21'd1529052;
  localparam logic [HALF_W-1:0] HALF_CS0 = 21'd1443418;
  localparam logic [HALF_W-1:0] HALF_D0  = 21'd1362398;
  localparam logic [HALF_W-1:0] HALF_DS0 = 21'd1285347;
  localparam logic [HALF_W-1:0] HALF_E0  = 21'd1213592;
  localparam logic [HALF_W-1:0] HALF_F0  = 21'd1145213;
  localparam logic [HALF_W-1:0] HALF_FS0 = 21'd1081315;
  localparam logic [HALF_W-1:0] HALF_G0  = 21'd1020408;
  localparam logic [HALF_W-1:0] HALF_GS0 = 21'd963020;
  localparam logic [HALF_W-1:0] HALF_A0  = 21'd909091;
  localparam logic [HALF_W-1:0] HALF_AS0 = 21'd857927;
  localparam logic [HALF_W-1:0] HALF_B0  = 21'd809848;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_DIV,
    S_HOLD,
    S_HALT
  } state_e;

  function automatic logic [HALF_W-1:0] semi_half(
    input logic [3:0] semi
  );
    case (semi)
      4'd0:    return HALF_C0;
      4'd1:    return HALF_CS0;
      4'd2:    return HALF_D0;
      4'd3:    return HALF_DS0;
      4'd4:    return HALF_E0;
      4'd5:    return HALF_F0;
      4'd6:    return HALF_FS0;
      4'd7:    return HALF_G0;
      4'd8:    return HALF_GS0;
      4'd9:    return HALF_A0;
      4'd10:   return HALF_AS0;
      4'd11:   return HALF_B0;
      default: return '0;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] note_half(
    input logic [3:0] semi,
    input logic [3:0] oct
  );
    logic [3:0] sh;
    sh = (oct > 4'd8) ? 4'd8 : oct;
    return semi_half(semi) >> sh;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: toggles its output every `half` cycles
// once loaded; a zero half-period silences it.
module tone_voice
  import tone_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [HALF_W-1:0] half_i,
  output logic              out_o
);

  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              out_q, out_d;

  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (load_i) begin
      half_d = half_i;
      cnt_d  = '0;
      if (half_i == '0) out_d = 1'b0;
    end else if (half_q != '0) begin
      if (cnt_q == half_q - 1'b1) begin
        cnt_d = '0;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/tone_sequencer.sv
// Multi-voice SRAM-driven sequencer: fetch/decode FSM, tempo
// divider, sixteenth-beat tick counter and CHANNELS voices.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          ADDR_W      = 18,
  parameter int          SRAM_LAT    = 2,
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int          DEFAULT_BPM = 96
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                RUN,
  output logic [ADDR_W-1:0]   SRAM_A,
  output logic                SRAM_OE,
  input  logic [15:0]         SRAM_D,
  output logic                SPEAKER,
  output logic [CHANNELS-1:0] CH_OUT,
  output logic                TICK,
  output logic [ADDR_W-1:0]   PC,
  output logic                HALTED
);

  localparam logic [63:0] DVD64 = 64'(CLK_HZ) * 64'd15;
  localparam logic [31:0] DVD = DVD64[31:0];
  localparam logic [31:0] RST_PERIOD =
    32'(DVD64 / 64'(DEFAULT_BPM));
  localparam logic [2:0] LAT_LAST = 3'(SRAM_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oe_q, oe_d;
  logic [15:0]       word_q, word_d;
  logic [2:0]        lat_q, lat_d;
  logic [3:0]        remain_q, remain_d;
  logic              halted_q, halted_d;
  logic [11:0]       div_q, div_d;
  logic [11:0]       drem_q, drem_d;
  logic [31:0]       dvd_q, dvd_d;
  logic [4:0]        dcnt_q, dcnt_d;
  logic [31:0]       period_q, period_d;
  logic [31:0]       active_q, active_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic              tick_q, tick_d;

  logic              is_set;
  logic [2:0]        sel;
  logic [11:0]       arg;
  logic [HALF_W-1:0] half;
  logic [12:0]       dsh;
  logic              dge;
  logic [31:0]       quot;
  logic              div_done;
  logic [CHANNELS-1:0] load_v;

  assign is_set = word_q[F_SET];
  assign sel    = word_q[F_SEL_LSB +: 3];
  assign arg    = word_q[11:0];
  assign half   = note_half(word_q[F_SEMI_LSB +: 4],
                            word_q[F_OCT_LSB +: 4]);

  // Restoring divide: shift one dividend bit into the remainder.
  assign dsh      = {drem_q, dvd_q[31]};
  assign dge      = dsh >= {1'b0, div_q};
  assign quot     = {dvd_q[30:0], dge};
  assign div_done = (state_q == S_DIV) && (dcnt_q == 5'd31);

  always_comb begin
    load_v = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load_v[i] = (state_q == S_DECODE) && !is_set &&
                  (sel == 3'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    oe_d     = oe_q;
    word_d   = word_q;
    lat_d    = lat_q;
    remain_d = remain_q;
    halted_d = halted_q;
    div_d    = div_q;
    drem_d   = drem_q;
    dvd_d    = dvd_q;
    dcnt_d   = dcnt_q;
    period_d = period_q;
    unique case (state_q)
      S_FETCH: begin
        if (RUN) begin
          addr_d  = pc_q;
          oe_d    = 1'b0;
          lat_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          word_d  = SRAM_D;
          oe_d    = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (is_set) begin
          unique case (1'b1)
            sel == OP_SET_BPM: begin
              div_d   = (arg == '0) ? 12'd1 : arg;
              dvd_d   = DVD;
              drem_d  = '0;
              dcnt_d  = '0;
              state_d = S_DIV;
            end
            sel == OP_END: begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            sel == OP_JUMP: pc_d = ADDR_W'(arg);
            default: ;
          endcase
        end else if (word_q[F_HOLD]) begin
          remain_d = {1'b0, word_q[F_DUR_LSB +: 3]} + 4'd1;
          state_d  = S_HOLD;
        end
      end
      S_DIV: begin
        drem_d = dge ? 12'(dsh - {1'b0, div_q}) : dsh[11:0];
        dvd_d  = quot;
        dcnt_d = dcnt_q + 5'd1;
        if (div_done) begin
          period_d = quot;
          state_d  = S_FETCH;
        end
      end
      S_HOLD: begin
        if (tick_q) begin
          if (remain_q == 4'd1) state_d = S_FETCH;
          else remain_d = remain_q - 4'd1;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // A fresh quotient is forwarded if it lands on the wrap cycle.
  always_comb begin
    tcnt_d   = tcnt_q;
    tick_d   = 1'b0;
    active_d = active_q;
    if (RUN) begin
      if (tcnt_q + 32'd1 >= active_q) begin
        tcnt_d   = '0;
        tick_d   = 1'b1;
        active_d = div_done ? quot : period_q;
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      addr_q   <= '0;
      oe_q     <= 1'b1;
      word_q   <= '0;
      lat_q    <= '0;
      remain_q <= '0;
      halted_q <= 1'b0;
      div_q    <= 12'(DEFAULT_BPM);
      drem_q   <= '0;
      dvd_q    <= '0;
      dcnt_q   <= '0;
      period_q <= RST_PERIOD;
      active_q <= RST_PERIOD;
      tcnt_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      oe_q     <= oe_d;
      word_q   <= word_d;
      lat_q    <= lat_d;
      remain_q <= remain_d;
      halted_q <= halted_d;
      div_q    <= div_d;
      drem_q   <= drem_d;
      dvd_q    <= dvd_d;
      dcnt_q   <= dcnt_d;
      period_q <= period_d;
      active_q <= active_d;
      tcnt_q   <= tcnt_d;
      tick_q   <= tick_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
    tone_voice u_voice (
      .clk    (CLK),
      .rst_n  (RST_N),
      .load_i (load_v[i]),
      .half_i (half),
      .out_o  (CH_OUT[i])
    );
  end

  assign SRAM_A  = addr_q;
  assign SRAM_OE = oe_q;
  assign PC      = pc_q;
  assign TICK    = tick_q;
  assign HALTED  = halted_q;
  assign SPEAKER = |CH_OUT;

endmodule
